// File: rtl/ensamblador_bytes_pkg.sv
// Shared definitions for the byte assembler: default sizes, FSM encoding, byte-lane mapping.
// Latency: none (declarations only).
// Backpressure: none.
package ensamblador_bytes_pkg;

   // Default frame size in bytes; the buffer is NUM_BYTES*8 bits wide.
   localparam int NUM_BYTES_DEF = 148;

   // Default maximum idle gap (in clk cycles) between bytes while receiving.
   localparam int TIMEOUT_CYCLES_DEF = 500000;

   // Receiver FSM encoding.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_DONE = 2'd2
   } estado_t;

   // Byte-lane mapping shared with the splitter: lane k sits at bits [8k+7:8k],
   // so the first byte on the wire ends up in the least significant lane.
   function automatic int byte_lane_lsb(input int lane);
      return lane * 8;
   endfunction

endpackage

// File: rtl/ensamblador_bytes_contador_timeout.sv
// Idle-gap counter: counts enabled cycles and flags the cycle on which the count would reach TIMEOUT_CYCLES.
// Latency: tc is combinational from the count register and enable; the counter restarts on the next edge.
// Backpressure: none; clear has priority over enable. TIMEOUT_CYCLES=0 never raises tc.
module ensamblador_bytes_contador_timeout
   import ensamblador_bytes_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)(
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [W-1:0] TC_VAL = (TIMEOUT_CYCLES > 0) ? W'(TIMEOUT_CYCLES - 1) : '0;

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Terminal count: the last allowed idle cycle is being consumed without a clear.
   assign tc = (TIMEOUT_CYCLES > 0) && enable && !clear && (cnt_q == TC_VAL);

   // Next count: clear wins, otherwise count enabled cycles and wrap to zero on terminal count.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = tc ? '0 : cnt_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ensamblador_bytes.sv
// Assembles NUM_BYTES UART bytes into one wide buffer; pulses done when the frame is complete.
// Latency: done is high the cycle after the edge that captures the last byte; all outputs registered.
// Backpressure: none; bytes are accepted only in RECV, an idle gap of TIMEOUT_CYCLES aborts the frame.
module ensamblador_bytes
   import ensamblador_bytes_pkg::*;
#(
   parameter int NUM_BYTES      = NUM_BYTES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)(
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           start,
   input  logic [7:0]                     rx_data,
   input  logic                           rx_done_tick,
   output logic [NUM_BYTES*8-1:0]         buffer_recibido,
   output logic [$clog2(NUM_BYTES+1)-1:0] byte_count,
   output logic                           busy,
   output logic                           buffer_valid,
   output logic                           done,
   output logic                           timeout_err
);

   localparam int CW = $clog2(NUM_BYTES + 1);
   localparam logic [CW-1:0] LAST_IDX = CW'(NUM_BYTES - 1);

   estado_t                state_q;
   estado_t                state_d;
   logic [NUM_BYTES*8-1:0] buffer_q;
   logic [NUM_BYTES*8-1:0] buffer_d;
   logic [CW-1:0]          byte_count_q;
   logic [CW-1:0]          byte_count_d;
   logic                   buffer_valid_q;
   logic                   buffer_valid_d;
   logic                   timeout_err_q;
   logic                   timeout_err_d;

   logic                   accept_start;
   logic                   byte_in;
   logic                   last_byte;
   logic                   timer_clear;
   logic                   timer_en;
   logic                   timer_tc;
   logic [NUM_BYTES-1:0]   lane_we;

   // A start is only honoured from IDLE; a tick only counts while receiving.
   assign accept_start = (state_q == ST_IDLE) && start;
   assign byte_in      = (state_q == ST_RECV) && rx_done_tick;
   assign last_byte    = byte_in && (byte_count_q == LAST_IDX);

   // The idle timer restarts on every accepted byte and when a frame is armed;
   // a tick on the expiry cycle therefore wins over the timeout.
   assign timer_clear  = accept_start || byte_in;
   assign timer_en     = (state_q == ST_RECV) && !rx_done_tick;

   ensamblador_bytes_contador_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (timer_clear),
      .enable  (timer_en),
      .tc      (timer_tc)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: arm on start, finish on the last byte, abort on idle timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RECV;
            end
         end
         ST_RECV: begin
            if (last_byte) begin
               state_d = ST_DONE;
            end else if (timer_tc) begin
               state_d = ST_IDLE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM outputs: pure decodes of the state register, so they carry no input-to-output path.
   always_comb begin
      busy = (state_q == ST_RECV);
      done = (state_q == ST_DONE);
   end

   // Per-lane write enables: only the lane addressed by the current byte count is written.
   always_comb begin
      lane_we = '0;
      for (int k = 0; k < NUM_BYTES; k++) begin
         lane_we[k] = byte_in && (byte_count_q == CW'(k));
      end
   end

   // Datapath next values: buffer lanes, byte count, frame-valid flag and timeout pulse.
   always_comb begin
      buffer_d       = buffer_q;
      byte_count_d   = byte_count_q;
      buffer_valid_d = buffer_valid_q;
      timeout_err_d  = 1'b0;

      for (int k = 0; k < NUM_BYTES; k++) begin
         if (lane_we[k]) begin
            buffer_d[byte_lane_lsb(k) +: 8] = rx_data;
         end
      end

      // Arming a frame resets the count and invalidates the old frame, but keeps its bytes.
      if (accept_start) begin
         byte_count_d   = '0;
         buffer_valid_d = 1'b0;
      end

      if (byte_in) begin
         byte_count_d = byte_count_q + 1'b1;
      end

      // Valid rises together with done and holds until the next accepted start.
      if (last_byte) begin
         buffer_valid_d = 1'b1;
      end

      // Aborted frame: partial bytes stay in the buffer, but the count is dropped.
      if (timer_tc) begin
         byte_count_d  = '0;
         timeout_err_d = 1'b1;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         buffer_q       <= '0;
         byte_count_q   <= '0;
         buffer_valid_q <= 1'b0;
         timeout_err_q  <= 1'b0;
      end else begin
         buffer_q       <= buffer_d;
         byte_count_q   <= byte_count_d;
         buffer_valid_q <= buffer_valid_d;
         timeout_err_q  <= timeout_err_d;
      end
   end

   assign buffer_recibido = buffer_q;
   assign byte_count      = byte_count_q;
   assign buffer_valid    = buffer_valid_q;
   assign timeout_err     = timeout_err_q;

endmodule

// File: tb/tb_ensamblador_bytes.sv
// Bench for ensamblador_bytes: directed scenarios plus random traffic against a frame-level model.
// Latency: expected done/timeout pulses are queued with their cycle stamp and matched by a monitor.
// Backpressure: none; the driver owns all inputs, the monitor only samples on the falling edge.
module tb_ensamblador_bytes;

   localparam int N  = 148;
   localparam int T  = 16;
   localparam int CW = $clog2(N + 1);

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             start = 1'b0;
   logic [7:0]       rx_data = 8'h00;
   logic             rx_done_tick = 1'b0;
   logic [N*8-1:0]   buffer_recibido;
   logic [CW-1:0]    byte_count;
   logic             busy;
   logic             buffer_valid;
   logic             done;
   logic             timeout_err;

   always #5 clk = ~clk;

   ensamblador_bytes #(
      .NUM_BYTES      (N),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .start           (start),
      .rx_data         (rx_data),
      .rx_done_tick    (rx_done_tick),
      .buffer_recibido (buffer_recibido),
      .byte_count      (byte_count),
      .busy            (busy),
      .buffer_valid    (buffer_valid),
      .done            (done),
      .timeout_err     (timeout_err)
   );

   typedef struct {
      bit             is_done;
      int             cyc;
      logic [N*8-1:0] img;
      int             cnt;
   } ev_t;

   ev_t evq[$];
   int  n_checks = 0;
   int  n_err    = 0;
   int  cyc      = 0;

   // Frame-level reference: what phase the receiver is in, bytes held, count, validity, silence length.
   typedef enum { PH_IDLE, PH_RECV, PH_DONE } ph_t;
   ph_t        m_ph;
   logic [7:0] m_buf [N];
   int         m_count;
   int         m_idle;
   bit         m_valid;

   function automatic logic [N*8-1:0] m_image();
      logic [N*8-1:0] v;
      v = '0;
      for (int k = 0; k < N; k++) v[8*k +: 8] = m_buf[k];
      return v;
   endfunction

   function automatic void model_reset();
      m_ph    = PH_IDLE;
      m_count = 0;
      m_idle  = 0;
      m_valid = 1'b0;
      for (int k = 0; k < N; k++) m_buf[k] = 8'h00;
   endfunction

   function automatic void push_ev(input bit is_done, input int cnt);
      ev_t e;
      e.is_done = is_done;
      e.cyc     = cyc;
      e.img     = m_image();
      e.cnt     = cnt;
      evq.push_back(e);
   endfunction

   // One clock edge of the reference, applied with the inputs that edge samples.
   function automatic void model_edge(input logic s, input logic t, input logic [7:0] d);
      case (m_ph)
         PH_DONE: m_ph = PH_IDLE;
         PH_IDLE: begin
            if (s) begin
               m_ph    = PH_RECV;
               m_count = 0;
               m_valid = 1'b0;
               m_idle  = 0;
            end
         end
         default: begin
            if (t) begin
               m_buf[m_count] = d;
               m_count++;
               m_idle = 0;
               if (m_count == N) begin
                  m_ph    = PH_DONE;
                  m_valid = 1'b1;
                  push_ev(1'b1, N);
               end
            end else begin
               m_idle++;
               if (m_idle == T) begin
                  m_ph    = PH_IDLE;
                  m_count = 0;
                  push_ev(1'b0, 0);
               end
            end
         end
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk_buf(input string nm, input logic [N*8-1:0] act, input logic [N*8-1:0] exp);
      int lane;
      n_checks++;
      if (act !== exp) begin
         lane = 0;
         for (int k = N - 1; k >= 0; k--) begin
            if (act[8*k +: 8] !== exp[8*k +: 8]) lane = k;
         end
         n_err++;
         $display("FAIL %s: lane %0d got %0h expected %0h (cycle %0d)",
                  nm, lane, act[8*lane +: 8], exp[8*lane +: 8], cyc);
      end
   endtask

   // Drive one cycle of inputs, advance the reference on the same edge, return just after it.
   task automatic step(input logic s, input logic t, input logic [7:0] d);
      start        = s;
      rx_done_tick = t;
      rx_data      = d;
      @(posedge clk);
      cyc++;
      model_edge(s, t, d);
      #1;
      start        = 1'b0;
      rx_done_tick = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, input int gap);
      repeat (gap) step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b1, d);
   endtask

   task automatic chk_all_zero(input string tag);
      chk_buf({tag, "_buf"}, buffer_recibido, '0);
      chk({tag, "_count"}, 32'(byte_count), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_valid"}, 32'(buffer_valid), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_timeout"}, 32'(timeout_err), 32'd0);
   endtask

   // Monitor: per-cycle status against the reference, pulses matched against the expected queue.
   always @(negedge clk) begin : mon
      ev_t e;
      if (reset_n) begin
         chk("busy", 32'(busy), 32'(m_ph == PH_RECV));
         chk("byte_count", 32'(byte_count), 32'(m_count));
         chk("buffer_valid", 32'(buffer_valid), 32'(m_valid));
         if (done || timeout_err) begin
            if (evq.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL unexpected_pulse: done=%0b timeout_err=%0b expected neither (cycle %0d)",
                        done, timeout_err, cyc);
            end else begin
               e = evq.pop_front();
               chk("ev_done", 32'(done), 32'(e.is_done));
               chk("ev_timeout", 32'(timeout_err), 32'(!e.is_done));
               chk("ev_cycle", 32'(cyc), 32'(e.cyc));
               chk("ev_count", 32'(byte_count), 32'(e.cnt));
               chk_buf("ev_buffer", buffer_recibido, e.img);
            end
         end
         while (evq.size() > 0 && evq[0].cyc < cyc) begin
            e = evq.pop_front();
            n_checks++;
            n_err++;
            $display("FAIL missed_pulse: is_done=%0b due cycle %0d not seen by cycle %0d",
                     e.is_done, e.cyc, cyc);
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      logic [7:0]     t3_bytes [3];
      logic [N*8-1:0] all55;
      int             p;

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      reset_n = 1'b1;

      // Ticks while idle are ignored.
      repeat (5) step(1'b0, 1'b1, 8'hAA);
      chk_buf("idle_ticks_buf", buffer_recibido, '0);
      chk("idle_ticks_count", 32'(byte_count), 32'd0);

      // Full frame with byte k = k.
      step(1'b1, 1'b0, 8'h00);
      for (int k = 0; k < N; k++) send_byte(8'(k), int'($urandom_range(0, 3)));
      chk("full_byte0", 32'(buffer_recibido[7:0]), 32'h00);
      chk("full_byte147", 32'(buffer_recibido[1183:1176]), 32'h93);
      chk("full_done", 32'(done), 32'd1);
      chk("full_count", 32'(byte_count), 32'd148);
      chk("full_valid", 32'(buffer_valid), 32'd1);
      step(1'b0, 1'b0, 8'h00);

      // Timeout after three bytes: partial bytes retained.
      step(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) begin
         t3_bytes[i] = 8'($urandom_range(0, 255));
         send_byte(t3_bytes[i], 1);
      end
      repeat (20) step(1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) chk("timeout_lane", 32'(buffer_recibido[8*i +: 8]), 32'(t3_bytes[i]));
      chk("timeout_count", 32'(byte_count), 32'd0);
      chk("timeout_valid", 32'(buffer_valid), 32'd0);

      // A tick on the last allowed idle cycle is stored and does not time out.
      step(1'b1, 1'b0, 8'h00);
      send_byte(8'h11, 0);
      repeat (T - 1) step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'h22);
      chk("edge_tick_count", 32'(byte_count), 32'd2);
      chk("edge_tick_lane1", 32'(buffer_recibido[15:8]), 32'h22);
      repeat (20) step(1'b0, 1'b0, 8'h00);

      // Reset in the middle of a frame, then a clean frame.
      step(1'b1, 1'b0, 8'h00);
      for (int k = 0; k < 70; k++) send_byte(8'($urandom_range(0, 255)), 0);
      reset_n = 1'b0;
      #1;
      chk_all_zero("midreset");
      @(posedge clk);
      @(posedge clk);
      #1;
      model_reset();
      reset_n = 1'b1;
      step(1'b1, 1'b0, 8'h00);
      for (int k = 0; k < N; k++) send_byte(8'($urandom_range(0, 255)), 0);

      // Back-to-back frame: start in the cycle right after done.
      step(1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 8'h00);
      chk("b2b_valid_drop", 32'(buffer_valid), 32'd0);
      for (int k = 0; k < N; k++) send_byte(8'h55, 0);
      all55 = {N{8'h55}};
      chk_buf("b2b_buf", buffer_recibido, all55);
      step(1'b0, 1'b0, 8'h00);

      // Random traffic: bursts of dense ticks (frames complete) and sparse ticks (timeouts).
      for (int blk = 0; blk < 30; blk++) begin
         p = (blk % 3 == 2) ? 30 : 2;
         for (int i = 0; i < 200; i++) begin
            step($urandom_range(0, 24) == 0, $urandom_range(0, p - 1) == 0,
                 8'($urandom_range(0, 255)));
         end
      end

      repeat (T + 4) step(1'b0, 1'b0, 8'h00);
      while (evq.size() > 0) begin
         n_checks++;
         n_err++;
         $display("FAIL leftover_event: is_done=%0b due cycle %0d never seen", evq[0].is_done, evq[0].cyc);
         void'(evq.pop_front());
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
